// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller with HI/LO register pair.
// Fixed-latency mult/div with busy stall signal and mthi/mtlo moves.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       pending;

    // Signed variants are the even opcodes (mult, div).
    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] div_result;

    assign is_signed = ~md_op[0];

    // A 64-bit product of correctly extended operands gives
    // the right low 64 bits for both signed and unsigned.
    assign ext_a   = {{32{is_signed & in_a[31]}}, in_a};
    assign ext_b   = {{32{is_signed & in_b[31]}}, in_b};
    assign product = ext_a * ext_b;

    // Divide on magnitudes, then restore signs. This keeps
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    assign neg_a    = is_signed & in_a[31];
    assign neg_b    = is_signed & in_b[31];
    assign mag_a    = neg_a ? (~in_a + 32'd1) : in_a;
    assign mag_b    = neg_b ? (~in_b + 32'd1) : in_b;
    assign div_zero = (in_b == 32'd0);
    assign divisor  = div_zero ? 32'd1 : mag_b;
    assign q_mag    = mag_a / divisor;
    assign r_mag    = mag_a % divisor;
    assign quot     = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem      = neg_a ? (~r_mag + 32'd1) : r_mag;

    // Divide by zero is not trapped: quotient all ones, rem = dividend.
    assign div_result = div_zero ? {in_a, 32'hFFFF_FFFF}
                                 : {rem, quot};

    // Sequencer: accept ops in IDLE, count down in RUN, commit at end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                pending <= product;
                                cnt     <= CNT_W'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pending <= div_result;
                                cnt     <= CNT_W'(DIV_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_MTHI: hi <= in_a;
                            OP_MTLO: lo <= in_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Any start seen here is ignored on purpose.
                    if (cnt == CNT_W'(1)) begin
                        {hi, lo} <= pending;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
